// File: rtl/mc_control_if.sv
// mc_control_if: opcode/status inputs and control outputs of the multicycle controller.
interface mc_control_if #(parameter int STATE_W = 4);
  logic [6:0] op;
  logic Zero, MemReady;
  logic PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;
  logic Illegal, InstrDone;
  logic [STATE_W-1:0] State;
  modport master(output op, Zero, MemReady,
                 input PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
                 ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Illegal, InstrDone, State);
  modport slave(input op, Zero, MemReady,
                output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Illegal, InstrDone, State);
endinterface

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle RISC-V control FSM with memory handshake, sticky trap and retire pulse.
module mc_control_fsm #(
  parameter bit ENABLE_UPPER = 1,
  parameter bit ENABLE_JALR = 1,
  parameter int STATE_W = 4
) (
  input logic clk,
  input logic rst_n,
  mc_control_if.slave bus
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4,
    MEMWRITE = 4'd5, EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9,
    JAL = 4'd10, JALR = 4'd11, UPPER = 4'd12, TRAP = 4'd13
  } state_t;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
    OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
    OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  state_t state, next;
  logic jalr_flag, illegal, instr_done, pc_update, branch;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FETCH;
      jalr_flag <= 1'b0;
      illegal <= 1'b0;
      instr_done <= 1'b0;
    end else begin
      state <= next;
      jalr_flag <= state == JALR;
      illegal <= illegal | (next == TRAP);
      instr_done <= next == FETCH && state != FETCH;
    end
  always_comb begin
    next = state;
    case (state)
      FETCH: next = bus.MemReady ? DECODE : FETCH;
      DECODE:
        case (bus.op)
          OP_LOAD, OP_STORE: next = MEMADR;
          OP_R: next = EXECR;
          OP_I: next = EXECI;
          OP_BR: next = BRANCH;
          OP_JAL: next = JAL;
          OP_JALR: next = ENABLE_JALR ? JALR : TRAP;
          OP_LUI, OP_AUIPC: next = ENABLE_UPPER ? UPPER : TRAP;
          default: next = TRAP;
        endcase
      MEMADR: next = bus.op == OP_LOAD ? MEMREAD : MEMWRITE;
      MEMREAD: next = bus.MemReady ? MEMWB : MEMREAD;
      MEMWRITE: next = bus.MemReady ? FETCH : MEMWRITE;
      MEMWB, ALUWB, BRANCH: next = FETCH;
      EXECR, EXECI, JAL, UPPER: next = ALUWB;
      JALR: next = JAL;
      TRAP: next = TRAP;
      default: next = FETCH;
    endcase
  end
  always_comb begin
    bus.AdrSrc = 1'b0;
    bus.IRWrite = 1'b0;
    bus.MemWrite = 1'b0;
    bus.RegWrite = 1'b0;
    bus.ResultSrc = 2'b00;
    bus.ALUSrcA = 2'b00;
    bus.ALUSrcB = 2'b00;
    bus.ALUOp = 2'b00;
    pc_update = 1'b0;
    branch = 1'b0;
    case (state)
      FETCH: begin
        bus.ALUSrcB = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.IRWrite = bus.MemReady;
        pc_update = bus.MemReady;
      end
      DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
      end
      MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
      end
      MEMREAD: bus.AdrSrc = 1'b1;
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite = 1'b1;
      end
      MEMWRITE: begin
        bus.AdrSrc = 1'b1;
        bus.MemWrite = 1'b1;
      end
      EXECR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUOp = 2'b10;
      end
      EXECI: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        bus.ALUOp = 2'b10;
      end
      ALUWB: bus.RegWrite = 1'b1;
      BRANCH: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUOp = 2'b01;
        branch = 1'b1;
      end
      JAL: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        pc_update = !jalr_flag;
      end
      JALR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        bus.ResultSrc = 2'b10;
        pc_update = 1'b1;
      end
      UPPER: begin
        // LUI adds the immediate to RD1 with rs1 forced to x0 by the datapath
        bus.ALUSrcA = bus.op == OP_AUIPC ? 2'b01 : 2'b10;
        bus.ALUSrcB = 2'b01;
      end
      default: ;
    endcase
  end
  always_comb begin
    bus.ImmSrc = 3'b000;
    case (bus.op)
      OP_STORE: bus.ImmSrc = 3'b001;
      OP_BR: bus.ImmSrc = 3'b010;
      OP_JAL: bus.ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC: bus.ImmSrc = 3'b100;
      default: ;
    endcase
  end
  assign bus.PCWrite = pc_update | (branch & bus.Zero);
  assign bus.Illegal = illegal;
  assign bus.InstrDone = instr_done;
  assign bus.State = STATE_W'(state);
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: random instruction streams checked against a per-instruction state-plan model.
module tb_mc_control_fsm;
  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4,
    S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BRANCH = 9, S_JAL = 10,
    S_JALR = 11, S_UPPER = 12, S_TRAP = 13;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011,
    BR = 7'b1100011, JL = 7'b1101111, JR = 7'b1100111, LUI = 7'b0110111, AUI = 7'b0010111,
    BAD = 7'b1111111;
  typedef struct {int st; bit mr; bit sup;} ent_t;
  logic clk = 1'b0, rst_n = 1'b1;
  int n_chk = 0, n_err = 0, prev_st = -1, zforce = -1;
  ent_t plan[$];
  logic [6:0] ops[9] = '{LW, SW, RT, IT, BR, JL, JR, LUI, AUI};
  always #5 clk = ~clk;
  mc_control_if #(.STATE_W(4)) bus();
  mc_control_if #(.STATE_W(4)) bus2();
  mc_control_fsm dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  mc_control_fsm #(.ENABLE_JALR(0), .ENABLE_UPPER(0)) dut2(.clk(clk), .rst_n(rst_n), .bus(bus2));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [12:0] exp_ctrl(int st, bit mr, bit sup, logic [6:0] op, bit z);
    logic pcw, irw, rw, mw, adr;
    logic [1:0] res, a, b, aop;
    {pcw, irw, rw, mw, adr} = '0;
    {res, a, b, aop} = '0;
    case (st)
      S_FETCH: begin pcw = mr; irw = mr; res = 2; b = 2; end
      S_DECODE: begin a = 1; b = 1; end
      S_MEMADR: begin a = 2; b = 1; end
      S_MEMREAD: adr = 1;
      S_MEMWB: begin res = 1; rw = 1; end
      S_MEMWRITE: begin adr = 1; mw = 1; end
      S_EXECR: begin a = 2; aop = 2; end
      S_EXECI: begin a = 2; b = 1; aop = 2; end
      S_ALUWB: rw = 1;
      S_BRANCH: begin a = 2; aop = 1; pcw = z; end
      S_JAL: begin a = 1; b = 2; pcw = !sup; end
      S_JALR: begin a = 2; b = 1; res = 2; pcw = 1; end
      S_UPPER: begin a = op == AUI ? 2'd1 : 2'd2; b = 1; end
      default: ;
    endcase
    return {pcw, irw, rw, mw, adr, res, a, b, aop};
  endfunction
  function automatic logic [2:0] exp_imm(logic [6:0] op);
    case (op)
      SW: return 3'd1;
      BR: return 3'd2;
      JL: return 3'd3;
      LUI, AUI: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction
  task automatic push(int st, bit mr, bit sup = 0);
    ent_t e;
    e.st = st; e.mr = mr; e.sup = sup;
    plan.push_back(e);
  endtask
  task automatic step(input ent_t e, input logic [6:0] op);
    bit z;
    @(negedge clk);
    z = zforce >= 0 ? zforce[0] : bit'($urandom_range(0, 1));
    bus.MemReady = e.mr;
    bus.Zero = z;
    #1;
    chk($sformatf("state%0d", e.st), bus.State, e.st);
    chk($sformatf("ctrl@%0d", e.st), {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite,
        bus.AdrSrc, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp},
        exp_ctrl(e.st, e.mr, e.sup, op, z));
    chk("instr_done", bus.InstrDone, e.st == S_FETCH && prev_st != -1 && prev_st != S_FETCH);
    chk("illegal", bus.Illegal, e.st == S_TRAP);
    if (e.st == S_DECODE) chk("imm_src", bus.ImmSrc, exp_imm(op));
    prev_st = e.st;
  endtask
  task automatic run(input logic [6:0] op, input int fw, input int mw);
    bit r;
    bus.op = op;
    plan.delete();
    r = bit'($urandom_range(0, 1));
    repeat (fw) push(S_FETCH, 0);
    push(S_FETCH, 1);
    push(S_DECODE, r);
    case (op)
      LW: begin
        push(S_MEMADR, r);
        repeat (mw) push(S_MEMREAD, 0);
        push(S_MEMREAD, 1);
        push(S_MEMWB, !r);
      end
      SW: begin
        push(S_MEMADR, !r);
        repeat (mw) push(S_MEMWRITE, 0);
        push(S_MEMWRITE, 1);
      end
      RT: begin push(S_EXECR, r); push(S_ALUWB, !r); end
      IT: begin push(S_EXECI, !r); push(S_ALUWB, r); end
      BR: push(S_BRANCH, r);
      JL: begin push(S_JAL, r); push(S_ALUWB, r); end
      JR: begin push(S_JALR, !r); push(S_JAL, r, 1); push(S_ALUWB, !r); end
      LUI, AUI: begin push(S_UPPER, r); push(S_ALUWB, !r); end
      default: repeat (10) push(S_TRAP, r);
    endcase
    foreach (plan[i]) step(plan[i], op);
  endtask
  task automatic reset_now(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_state"}, bus.State, S_FETCH);
    chk({tag, "_illegal"}, bus.Illegal, 0);
    chk({tag, "_done"}, bus.InstrDone, 0);
    chk({tag, "_memwrite"}, bus.MemWrite, 0);
    bus.MemReady = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    prev_st = -1;
  endtask
  initial begin
    bus.op = RT; bus.Zero = 0; bus.MemReady = 0;
    bus2.op = JR; bus2.Zero = 0; bus2.MemReady = 1;
    #1;
    reset_now("por");
    run(RT, 0, 0);
    run(LW, 1, 3);
    zforce = 1;
    run(BR, 0, 0);
    zforce = 0;
    run(BR, 0, 0);
    zforce = -1;
    run(JR, 0, 0);
    run(LUI, 0, 0);
    run(AUI, 2, 0);
    repeat (250) run(ops[$urandom_range(0, 8)], $urandom_range(0, 3), $urandom_range(0, 3));
    bus.op = SW;
    plan.delete();
    push(S_FETCH, 1); push(S_DECODE, 1); push(S_MEMADR, 1);
    push(S_MEMWRITE, 0); push(S_MEMWRITE, 0);
    foreach (plan[i]) step(plan[i], SW);
    chk("sw_wait_memwrite", bus.MemWrite, 1);
    reset_now("rst_in_memwrite");
    run(BAD, 1, 0);
    reset_now("rst_in_trap");
    chk("nojalr_not_trapped", bus2.Illegal, 0);
    run(RT, 0, 0);
    chk("nojalr_state", bus2.State, S_TRAP);
    chk("nojalr_illegal", bus2.Illegal, 1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
